// File: rtl/uart_pkg.sv
// Shared UART definitions: divider register layout, default oversample ratio
// and a helper that turns a clock/baud pair into divider register values.
package uart_pkg;

  localparam int BAUD_DIV_WIDTH  = 16;
  localparam int BAUD_FRAC_WIDTH = 4;
  localparam int UART_OVERSAMPLE = 16;

  typedef struct packed {
    logic [BAUD_DIV_WIDTH-1:0]  div_int;
    logic [BAUD_FRAC_WIDTH-1:0] div_frac;
  } baud_divider_t;

  // Oversample period in clock cycles is D + 1 + F/2^FRAC, so the period is
  // computed in fixed point with FRAC fraction bits, rounded to nearest, and
  // split into the integer and fractional register fields.
  function automatic baud_divider_t calc_baud_divider(input longint unsigned clk_hz,
                                                      input longint unsigned baud_hz);
    longint unsigned scale;
    longint unsigned denom;
    longint unsigned period_fx;
    longint unsigned whole;
    baud_divider_t   result;
    scale     = longint'(1) << BAUD_FRAC_WIDTH;
    denom     = baud_hz * longint'(UART_OVERSAMPLE);
    period_fx = (clk_hz * scale + denom / 2) / denom;
    whole     = period_fx >> BAUD_FRAC_WIDTH;
    result.div_int  = (whole == 0) ? '0 : BAUD_DIV_WIDTH'(whole - 1);
    result.div_frac = BAUD_FRAC_WIDTH'(period_fx);
    return result;
  endfunction

endpackage

// File: rtl/uart_frac_baud_generator_if.sv
// Control and tick bundle between a UART controller (master) and the
// fractional baud generator (slave).
interface uart_frac_baud_generator_if
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH  = BAUD_DIV_WIDTH,
  parameter int FRAC_WIDTH = BAUD_FRAC_WIDTH
);

  logic                  enable_i;
  logic                  sync_i;
  logic [DIV_WIDTH-1:0]  divider_int_i;
  logic [FRAC_WIDTH-1:0] divider_frac_i;
  logic                  oversample_tick_o;
  logic                  bit_tick_o;
  logic                  mid_bit_o;

  modport master (
    output enable_i, sync_i, divider_int_i, divider_frac_i,
    input  oversample_tick_o, bit_tick_o, mid_bit_o
  );

  modport slave (
    input  enable_i, sync_i, divider_int_i, divider_frac_i,
    output oversample_tick_o, bit_tick_o, mid_bit_o
  );

endinterface

// File: rtl/uart_tick_phase_counter.sv
// Modulo-OVERSAMPLE phase counter driven by the oversample tick. Emits the
// bit-boundary pulse when the phase wraps to 0 and the centre-sample pulse
// when the phase reaches OVERSAMPLE/2. Shared with the RX sampler.
module uart_tick_phase_counter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic tick_i,
  input  logic sync_i,
  output logic bit_tick_o,
  output logic mid_bit_o
);

  localparam int PHASE_WIDTH = $clog2(OVERSAMPLE);
  localparam logic [PHASE_WIDTH-1:0] LAST_PHASE    = PHASE_WIDTH'(OVERSAMPLE - 1);
  localparam logic [PHASE_WIDTH-1:0] PRE_MID_PHASE = PHASE_WIDTH'(OVERSAMPLE / 2 - 1);
  localparam logic [PHASE_WIDTH-1:0] PHASE_ONE     = PHASE_WIDTH'(1);

  logic [PHASE_WIDTH-1:0] phase_q;

  // Advance the phase on each tick and register the pulses for the tick that lands on 0 or OVERSAMPLE/2.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      phase_q    <= '0;
      bit_tick_o <= 1'b0;
      mid_bit_o  <= 1'b0;
    end else if (sync_i) begin
      phase_q    <= '0;
      bit_tick_o <= 1'b0;
      mid_bit_o  <= 1'b0;
    end else begin
      bit_tick_o <= tick_i && (phase_q == LAST_PHASE);
      mid_bit_o  <= tick_i && (phase_q == PRE_MID_PHASE);
      if (tick_i) begin
        phase_q <= (phase_q == LAST_PHASE) ? '0 : phase_q + PHASE_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_frac_baud_generator.sv
// Fractional baud-rate generator. A cycle counter divides the clock by D+1,
// stretched by one cycle whenever the fractional accumulator carries, giving
// an average oversample period of D + 1 + F/2^FRAC_WIDTH cycles. The divider
// is shadowed so changes only take effect at a period boundary.
module uart_frac_baud_generator
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH  = BAUD_DIV_WIDTH,
  parameter int FRAC_WIDTH = BAUD_FRAC_WIDTH,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  uart_frac_baud_generator_if.slave  bus
);

  localparam logic [DIV_WIDTH:0] CNT_ONE = (DIV_WIDTH+1)'(1);

  logic [DIV_WIDTH:0]    cnt_q;
  logic [FRAC_WIDTH-1:0] acc_q;
  logic                  carry_q;
  logic [DIV_WIDTH-1:0]  d_act_q;
  logic [FRAC_WIDTH-1:0] f_act_q;
  logic                  loaded_q;
  logic                  tick_q;

  logic [DIV_WIDTH-1:0]  d_eff;
  logic [FRAC_WIDTH-1:0] f_eff;
  logic [DIV_WIDTH:0]    limit;
  logic [FRAC_WIDTH:0]   acc_sum;
  logic                  tick;

  // Until the shadows have captured the inputs once after reset, the inputs
  // themselves define the first period.
  assign d_eff   = loaded_q ? d_act_q : bus.divider_int_i;
  assign f_eff   = loaded_q ? f_act_q : bus.divider_frac_i;
  assign limit   = {1'b0, d_eff} + {{DIV_WIDTH{1'b0}}, carry_q};
  assign acc_sum = {1'b0, acc_q} + {1'b0, f_eff};
  assign tick    = bus.enable_i && !bus.sync_i && (cnt_q >= limit);

  // Cycle counter, fractional accumulator, carry flag and divider shadows.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      d_act_q  <= '0;
      f_act_q  <= '0;
      loaded_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      loaded_q <= 1'b1;
      if (bus.sync_i) begin
        cnt_q   <= '0;
        acc_q   <= '0;
        carry_q <= 1'b0;
        d_act_q <= bus.divider_int_i;
        f_act_q <= bus.divider_frac_i;
        tick_q  <= 1'b0;
      end else begin
        tick_q <= tick;
        if (!loaded_q || tick) begin
          d_act_q <= bus.divider_int_i;
          f_act_q <= bus.divider_frac_i;
        end
        if (tick) begin
          cnt_q   <= '0;
          acc_q   <= acc_sum[FRAC_WIDTH-1:0];
          carry_q <= acc_sum[FRAC_WIDTH];
        end else if (bus.enable_i) begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end
    end
  end

  uart_tick_phase_counter #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_phase (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .tick_i     (tick),
    .sync_i     (bus.sync_i),
    .bit_tick_o (bus.bit_tick_o),
    .mid_bit_o  (bus.mid_bit_o)
  );

  assign bus.oversample_tick_o = tick_q;

endmodule

// File: tb/tb_uart_frac_baud_generator.sv
// Directed bench for the fractional baud generator: a table of divider
// settings with hand-computed tick gaps, plus sequences for bit/mid timing,
// sync, enable hold, divider change and asynchronous reset.
module tb_uart_frac_baud_generator;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  f;
    logic [47:0] gaps;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   nChecks = 0;
  int   nFails  = 0;
  int   edgeNum = 0;
  vec_t vecs [6];

  logic os, bt, mb;

  uart_frac_baud_generator_if #(.DIV_WIDTH(16), .FRAC_WIDTH(4)) bus ();

  uart_frac_baud_generator #(
    .DIV_WIDTH  (16),
    .FRAC_WIDTH (4),
    .OVERSAMPLE (16)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  assign os = bus.oversample_tick_o;
  assign bt = bus.bit_tick_o;
  assign mb = bus.mid_bit_o;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Pulses other than the oversample tick must never stand alone.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      nChecks++;
      if ((bt || mb) && !os) begin
        nFails++;
        $display("[TB] FAIL pulse without oversample tick: bit=%0d mid=%0d tick=%0d", bt, mb, os);
      end
    end
  end

  task automatic stepEdge();
    @(posedge clk);
    #1;
    edgeNum++;
  endtask

  task automatic stepTo(input int target);
    while (edgeNum < target) stepEdge();
  endtask

  task automatic waitTick(input int limit, output int at);
    bit found;
    found = 1'b0;
    at = -1;
    for (int i = 0; i < limit && !found; i++) begin
      stepEdge();
      if (os) begin
        at = edgeNum;
        found = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] f);
    bus.enable_i       = 1'b1;
    bus.sync_i         = 1'b0;
    bus.divider_int_i  = d;
    bus.divider_frac_i = f;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset outputs", int'({os, bt, mb}), 0);
    #2 rst_n = 1'b1;
    edgeNum = 0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t, prev, t1, cnt, last, bad;
    int firstOs, firstMid, firstBit, secondMid, secondBit, syncEdge;

    vecs[0] = '{d: 16'd3, f: 4'd0,  gaps: {8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4}};
    vecs[1] = '{d: 16'd3, f: 4'd8,  gaps: {8'd4, 8'd4, 8'd5, 8'd4, 8'd5, 8'd4}};
    vecs[2] = '{d: 16'd0, f: 4'd0,  gaps: {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}};
    vecs[3] = '{d: 16'd1, f: 4'd4,  gaps: {8'd2, 8'd2, 8'd2, 8'd2, 8'd3, 8'd2}};
    vecs[4] = '{d: 16'd5, f: 4'd15, gaps: {8'd6, 8'd6, 8'd7, 8'd7, 8'd7, 8'd7}};
    vecs[5] = '{d: 16'd2, f: 4'd1,  gaps: {8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3}};

    rst_n = 1'b0;
    bus.enable_i = 1'b0;
    bus.sync_i = 1'b0;
    bus.divider_int_i = '0;
    bus.divider_frac_i = '0;
    #12;

    // Table: gap from reset release to first tick, then between ticks.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].d, vecs[i].f);
      prev = 0;
      for (int k = 0; k < 6; k++) begin
        waitTick(40, t);
        checkOutput($sformatf("vec%0d gap%0d", i, k), (t < 0) ? -1 : t - prev,
                    int'(vecs[i].gaps[47 - 8*k -: 8]));
        prev = t;
      end
    end

    // Bit and mid-bit placement with D=3.
    applyStimulus(16'd3, 4'd0);
    cnt = 0; firstMid = -1; secondMid = -1; firstBit = -1; secondBit = -1;
    for (int e = 0; e < 128; e++) begin
      stepEdge();
      if (os) cnt++;
      if (mb) begin
        if (firstMid < 0) firstMid = edgeNum; else if (secondMid < 0) secondMid = edgeNum;
      end
      if (bt) begin
        if (firstBit < 0) firstBit = edgeNum; else if (secondBit < 0) secondBit = edgeNum;
      end
    end
    checkOutput("ticks in 128 cycles", cnt, 32);
    checkOutput("first mid_bit edge", firstMid, 32);
    checkOutput("first bit_tick edge", firstBit, 64);
    checkOutput("second mid_bit edge", secondMid, 96);
    checkOutput("second bit_tick edge", secondBit, 128);

    // Fractional D=3 F=8: 16 ticks in the 72 cycles after the first.
    applyStimulus(16'd3, 4'd8);
    waitTick(20, t1);
    checkOutput("frac first tick", t1, 4);
    cnt = 0; last = -1;
    for (int e = 0; e < 72; e++) begin
      stepEdge();
      if (os) begin
        cnt++;
        last = edgeNum;
      end
    end
    checkOutput("frac ticks in 72", cnt, 16);
    checkOutput("frac last tick offset", last - t1, 72);

    // Sync on the cycle a tick is due, after five ticks have moved the phase.
    applyStimulus(16'd3, 4'd0);
    stepTo(23);
    bus.sync_i = 1'b1;
    stepEdge();
    syncEdge = edgeNum;
    checkOutput("sync suppresses tick", int'(os), 0);
    bus.sync_i = 1'b0;
    firstOs = -1; firstMid = -1; firstBit = -1;
    for (int e = 0; e < 70; e++) begin
      stepEdge();
      if (os && firstOs < 0) firstOs = edgeNum - syncEdge;
      if (mb && firstMid < 0) firstMid = edgeNum - syncEdge;
      if (bt && firstBit < 0) firstBit = edgeNum - syncEdge;
    end
    checkOutput("sync next tick offset", firstOs, 4);
    checkOutput("sync mid_bit offset", firstMid, 32);
    checkOutput("sync bit_tick offset", firstBit, 64);

    // Enable dropped for 10 cycles with the counter at 5, D=9.
    applyStimulus(16'd9, 4'd0);
    stepTo(15);
    bus.enable_i = 1'b0;
    bad = 0;
    for (int e = 0; e < 10; e++) begin
      stepEdge();
      if (os || bt || mb) bad++;
    end
    checkOutput("outputs while disabled", bad, 0);
    bus.enable_i = 1'b1;
    waitTick(30, t);
    checkOutput("resumed tick edge", t, 30);
    waitTick(30, t);
    checkOutput("tick after resume", t, 40);

    // Divider change 9 -> 2 with the counter at 5.
    applyStimulus(16'd9, 4'd0);
    stepTo(15);
    bus.divider_int_i = 16'd2;
    waitTick(30, t);
    checkOutput("period completes at 10", t, 20);
    waitTick(30, t);
    checkOutput("new period 3 first", t, 23);
    waitTick(30, t);
    checkOutput("new period 3 second", t, 26);

    // Asynchronous reset between edges while the tick is high.
    applyStimulus(16'd3, 4'd0);
    stepTo(8);
    checkOutput("tick high before reset", int'(os), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset drops outputs", int'({os, bt, mb}), 0);
    applyStimulus(16'd3, 4'd0);
    firstOs = -1; firstMid = -1;
    for (int e = 0; e < 40; e++) begin
      stepEdge();
      if (os && firstOs < 0) firstOs = edgeNum;
      if (mb && firstMid < 0) firstMid = edgeNum;
    end
    checkOutput("restart first tick", firstOs, 4);
    checkOutput("restart first mid_bit", firstMid, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
